// File: rtl/sdram_req_scheduler.sv
// Burst request scheduler: refresh first, then starved masters, then open-row hits, then round-robin.
// One command outstanding at a time; the open row of every bank is tracked for hit detection.
module sdram_req_scheduler #(
  parameter int N_MASTERS   = 2,
  parameter int W_HADDR     = 32,
  parameter int COLUMN_BITS = 10,
  parameter int ROW_BITS    = 13,
  parameter int W_BANKSEL   = 2,
  parameter int MAX_WAIT    = 4,
  localparam int W_MST      = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_MASTERS-1:0]           req_valid,
  input  logic [N_MASTERS-1:0]           req_write,
  input  logic [N_MASTERS*W_HADDR-1:0]   req_addr,
  output logic [N_MASTERS-1:0]           req_ready,
  input  logic                           refresh_req,
  output logic                           refresh_ack,
  output logic                           cmd_valid,
  input  logic                           cmd_ready,
  output logic                           cmd_refresh,
  output logic [W_MST-1:0]               cmd_master,
  output logic                           cmd_write,
  output logic [W_BANKSEL-1:0]           cmd_bank,
  output logic [ROW_BITS-1:0]            cmd_row,
  output logic [COLUMN_BITS-1:0]         cmd_col,
  output logic                           cmd_bank_open,
  output logic                           cmd_row_hit,
  input  logic                           done
);

  localparam int N_BANKS = 1 << W_BANKSEL;
  localparam int BANK_LO = COLUMN_BITS + 1;
  localparam int ROW_LO  = COLUMN_BITS + W_BANKSEL + 1;
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_e;

  state_e                 state_q;
  logic [W_MST-1:0]       last_grant_q;
  logic [3:0]             wait_cnt_q [N_MASTERS];
  logic [N_BANKS-1:0]     open_valid_q;
  logic [ROW_BITS-1:0]    open_row_q [N_BANKS];

  logic                   cmd_valid_q, cmd_refresh_q, cmd_write_q;
  logic                   cmd_bank_open_q, cmd_row_hit_q;
  logic [W_MST-1:0]       cmd_master_q;
  logic [W_BANKSEL-1:0]   cmd_bank_q;
  logic [ROW_BITS-1:0]    cmd_row_q;
  logic [COLUMN_BITS-1:0] cmd_col_q;

  logic [COLUMN_BITS-1:0] m_col  [N_MASTERS];
  logic [W_BANKSEL-1:0]   m_bank [N_MASTERS];
  logic [ROW_BITS-1:0]    m_row  [N_MASTERS];
  logic [N_MASTERS-1:0]   m_open, m_hit, forced_mask, hit_mask;
  logic [W_MST-1:0]       sel_master_d;
  logic                   accept;
  logic                   unused_addr;

  // Bit 0 and the bits above the row field carry no SDRAM meaning.
  assign unused_addr = ^req_addr;

  for (genvar k = 0; k < N_MASTERS; k++) begin : g_dec
    assign m_col[k]       = req_addr[k*W_HADDR + 1 +: COLUMN_BITS];
    assign m_bank[k]      = req_addr[k*W_HADDR + BANK_LO +: W_BANKSEL];
    assign m_row[k]       = req_addr[k*W_HADDR + ROW_LO +: ROW_BITS];
    assign m_open[k]      = open_valid_q[m_bank[k]];
    assign m_hit[k]       = m_open[k] && (open_row_q[m_bank[k]] == m_row[k]);
    assign forced_mask[k] = req_valid[k] && (wait_cnt_q[k] == WAIT_MAX);
  end

  assign hit_mask = req_valid & m_hit;

  function automatic logic [W_MST-1:0] rr_pick(input logic [N_MASTERS-1:0] mask,
                                               input logic [W_MST-1:0]     last);
    logic found;
    found   = 1'b0;
    rr_pick = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (!found && mask[k] && (k > int'(last))) begin
        rr_pick = W_MST'(k);
        found   = 1'b1;
      end
    end
    // Wrap around to the masters at or below the last grant.
    for (int k = 0; k < N_MASTERS; k++) begin
      if (!found && mask[k]) begin
        rr_pick = W_MST'(k);
        found   = 1'b1;
      end
    end
  endfunction

  assign sel_master_d = (|forced_mask) ? rr_pick(forced_mask, last_grant_q) :
                        (|hit_mask)    ? rr_pick(hit_mask, last_grant_q) :
                                         rr_pick(req_valid, last_grant_q);

  assign accept = cmd_valid_q && cmd_ready;

  always_comb begin
    req_ready = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      req_ready[k] = accept && !cmd_refresh_q && (cmd_master_q == W_MST'(k));
    end
  end

  assign refresh_ack   = accept && cmd_refresh_q;
  assign cmd_valid     = cmd_valid_q;
  assign cmd_refresh   = cmd_refresh_q;
  assign cmd_master    = cmd_master_q;
  assign cmd_write     = cmd_write_q;
  assign cmd_bank      = cmd_bank_q;
  assign cmd_row       = cmd_row_q;
  assign cmd_col       = cmd_col_q;
  assign cmd_bank_open = cmd_bank_open_q;
  assign cmd_row_hit   = cmd_row_hit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      last_grant_q    <= W_MST'(N_MASTERS - 1);
      open_valid_q    <= '0;
      cmd_valid_q     <= 1'b0;
      cmd_refresh_q   <= 1'b0;
      cmd_write_q     <= 1'b0;
      cmd_master_q    <= '0;
      cmd_bank_q      <= '0;
      cmd_row_q       <= '0;
      cmd_col_q       <= '0;
      cmd_bank_open_q <= 1'b0;
      cmd_row_hit_q   <= 1'b0;
      for (int k = 0; k < N_MASTERS; k++) wait_cnt_q[k] <= '0;
      for (int b = 0; b < N_BANKS; b++) open_row_q[b] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (refresh_req) begin
            state_q         <= S_ISSUE;
            cmd_valid_q     <= 1'b1;
            cmd_refresh_q   <= 1'b1;
            cmd_write_q     <= 1'b0;
            cmd_master_q    <= '0;
            cmd_bank_q      <= '0;
            cmd_row_q       <= '0;
            cmd_col_q       <= '0;
            cmd_bank_open_q <= 1'b0;
            cmd_row_hit_q   <= 1'b0;
          end else if (|req_valid) begin
            state_q         <= S_ISSUE;
            cmd_valid_q     <= 1'b1;
            cmd_refresh_q   <= 1'b0;
            cmd_master_q    <= sel_master_d;
            cmd_write_q     <= req_write[sel_master_d];
            cmd_bank_q      <= m_bank[sel_master_d];
            cmd_row_q       <= m_row[sel_master_d];
            cmd_col_q       <= m_col[sel_master_d];
            cmd_bank_open_q <= m_open[sel_master_d];
            cmd_row_hit_q   <= m_hit[sel_master_d];
            last_grant_q    <= sel_master_d;
            for (int k = 0; k < N_MASTERS; k++) begin
              if (W_MST'(k) == sel_master_d) begin
                wait_cnt_q[k] <= '0;
              end else if (req_valid[k] && (wait_cnt_q[k] != WAIT_MAX)) begin
                wait_cnt_q[k] <= wait_cnt_q[k] + 4'd1;
              end
            end
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            state_q     <= S_BUSY;
            cmd_valid_q <= 1'b0;
            if (cmd_refresh_q) begin
              open_valid_q <= '0;
            end else begin
              open_valid_q[cmd_bank_q] <= 1'b1;
              open_row_q[cmd_bank_q]   <= cmd_row_q;
            end
          end
        end
        S_BUSY: begin
          if (done) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sdram_req_scheduler.md
# sdram_req_scheduler

Burst-level request scheduler between the AHB-Lite master ports and the SDRAM command engine. It accepts one pending 4-beat burst request per master plus an auto-refresh request. It picks one request at a time using refresh priority, then open-row hits, then round-robin, with a starvation bound. For the chosen request it presents decoded bank/row/column and open-row status to the engine. It keeps one outstanding burst at a time and tracks the open row of every bank.

## Interface
Parameters:
- N_MASTERS, 2, number of request channels (≥2)
- W_HADDR, 32, request address width (byte address)
- COLUMN_BITS, 10, SDRAM column address bits
- ROW_BITS, 13, SDRAM row address bits
- W_BANKSEL, 2, bank select bits
- MAX_WAIT, 4, grants lost by a waiting master before it is forced (1..15)

Ports (W_MST = max(1, clog2(N_MASTERS))):
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_MASTERS  burst request pending, per master
- req_write  in  N_MASTERS  1 = write burst
- req_addr  in  N_MASTERS*W_HADDR  byte address; master k in bits [k*W_HADDR +: W_HADDR]
- req_ready  out  N_MASTERS  one-cycle accept pulse, per master
- refresh_req  in  1  refresh due (level)
- refresh_ack  out  1  one-cycle pulse when the refresh command is accepted
- cmd_valid  out  1  command presented
- cmd_ready  in  1  engine accepts command
- cmd_refresh  out  1  command is a refresh (all-bank precharge + REF)
- cmd_master  out  W_MST  granted master
- cmd_write  out  1  write burst
- cmd_bank  out  W_BANKSEL  bank
- cmd_row  out  ROW_BITS  row
- cmd_col  out  COLUMN_BITS  column
- cmd_bank_open  out  1  bank has an open row
- cmd_row_hit  out  1  open row equals cmd_row
- done  in  1  engine finished the current command (one-cycle pulse)

## Operation
- Address decode: col = addr[COLUMN_BITS:1]; bank = addr[COLUMN_BITS+W_BANKSEL:COLUMN_BITS+1]; row = next ROW_BITS bits. Bit 0 and address bits above the row field are ignored.
- Per-bank state: open_valid[b] and open_row[b].
  - On acceptance of a non-refresh command: open_valid[bank] ← 1, open_row[bank] ← row.
  - On acceptance of a refresh command: all open_valid ← 0.
- FSM:
  - IDLE → ISSUE when refresh_req or any req_valid.
  - ISSUE → BUSY on cmd_valid & cmd_ready.
  - BUSY → IDLE on done.
- Selection is made and registered in IDLE, in this priority order:
  - refresh_req wins.
  - Otherwise, among valid masters with wait_cnt == MAX_WAIT, round-robin.
  - Otherwise, among valid row-hit masters, round-robin.
  - Otherwise, among all valid masters, round-robin.
- Round-robin: search starts at (last_grant+1) mod N_MASTERS. last_grant resets to N_MASTERS-1, so master 0 has first priority after reset.
- wait_cnt[k]:
  - On each master grant to another master while req_valid[k] is high: increment, saturating at MAX_WAIT.
  - On grant to k: cleared.
  - Refresh grants leave it unchanged.
- last_grant updates only on master grants.
- req_ready[k] = cmd_valid & cmd_ready & !cmd_refresh & cmd_master==k. Same for refresh_ack with cmd_refresh.
- Masters hold req_valid, req_write and req_addr stable until req_ready. Deassertion before grant is illegal.
- cmd_* fields are registered at the IDLE→ISSUE transition and stay stable while cmd_valid is high.
- cmd_row_hit / cmd_bank_open reflect bank state at selection time. Bank state cannot change during ISSUE because only one command is outstanding.

## Timing
- Reset values:
  - Outputs: cmd_valid, cmd_refresh, cmd_write, cmd_master, cmd_bank, cmd_row, cmd_col, cmd_bank_open, cmd_row_hit, req_ready and refresh_ack are all 0.
  - Internal: open_valid all 0, wait_cnt all 0, FSM IDLE.
- Latency: request visible in IDLE at cycle n → cmd_valid high at n+1. With cmd_ready already high, req_ready pulses at n+1.
- done at cycle d (in BUSY) → IDLE at d+1 → next cmd_valid no earlier than d+2.
- done outside BUSY is ignored. cmd_ready outside ISSUE is ignored.
- refresh_req and a master request arriving in the same IDLE cycle: refresh is issued first; the master is granted after refresh done.
- refresh_req asserted during BUSY: takes effect at the next IDLE.
- Asynchronous rst in any state: immediate return to reset values. In-flight commands are forgotten; no pulses are emitted.

## Test plan
- Single request: master 0, write, addr 0x0000_0810 → cmd_valid one cycle later with bank=1, row=0, col=8, cmd_bank_open=0. With cmd_ready=1, req_ready[0] pulses; done → IDLE.
- Round-robin: both masters hold rows that miss → grants alternate 0,1,0,1 across 4 bursts.
- Row-hit preference: bank 0 open at row 3. M0 requests row 5, M1 requests row 3 (bank 0) → M1 granted with cmd_row_hit=1, even though the round-robin pointer favours M0.
- Starvation, MAX_WAIT=2: M1 repeatedly row-hits while M0 misses → M0 is granted on the third decision, with cmd_row_hit=0.
- Refresh: refresh_req and M0 request in the same cycle → cmd_refresh=1 first and refresh_ack pulses. After done, open_valid is clear, so M0's next burst shows cmd_bank_open=0.
- Reset mid-ISSUE: rst during cmd_valid=1 → cmd_valid=0 immediately. After release, a master 1 request is granted with cmd_bank_open=0.
